// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the dual-clock FIFO: issues reads, captures the registered
// read data and re-presents it on a valid/ready stream through a 2-entry skid buffer.
module fifo_rd_stream #(
    parameter int DATA = 14,
    parameter int CNTW = 16
) (
    input  logic            rclk,
    input  logic            rst,
    input  logic            en,
    input  logic            fifo_empty,
    input  logic [DATA-1:0] fifo_data,
    output logic            fifo_r_en,
    output logic [DATA-1:0] m_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [CNTW-1:0] rd_count,
    output logic            idle
);

    logic [1:0]      occ;
    logic [1:0]      occ_after_pop;
    logic [1:0]      occ_next;
    logic            inflight;
    logic [DATA-1:0] slot1;
    logic [DATA-1:0] head_next;
    logic [DATA-1:0] slot1_next;
    logic            pop;
    logic [2:0]      committed;

    assign pop = m_valid & m_ready;

    // Words already owed a buffer slot once this cycle's pop retires; a new read is
    // only issued when it is guaranteed somewhere to land.
    assign committed = 3'(occ) + 3'(inflight) - 3'(pop);
    assign fifo_r_en = rst & en & ~fifo_empty & (committed < 3'd2);

    assign idle = (occ == 2'd0) & ~inflight;

    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        head_next     = m_data;
        slot1_next    = slot1;
        occ_after_pop = occ;
        if (pop) begin
            occ_after_pop = occ - 2'd1;
            if (occ == 2'd2) begin
                head_next = slot1;
            end
        end
        occ_next = occ_after_pop;
        if (inflight) begin
            if (occ_after_pop == 2'd0) begin
                head_next = fifo_data;
            end else begin
                slot1_next = fifo_data;
            end
            occ_next = occ_after_pop + 2'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // values from before the edge; the two data slots are reset too, so m_data
    // comes up as zero rather than whatever the flops power up with.
    always_ff @(posedge rclk or negedge rst) begin
        if (!rst) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            slot1    <= '0;
            rd_count <= '0;
        end else begin
            occ      <= occ_next;
            inflight <= fifo_r_en;
            m_valid  <= (occ_next != 2'd0);
            m_data   <= head_next;
            slot1    <= slot1_next;
            rd_count <= rd_count + CNTW'(pop);
        end
    end

    // A capture arriving while both slots stay full would drop a word.
    a_no_overflow : assert property (@(posedge rclk) disable iff (!rst)
        !(inflight && occ_after_pop == 2'd2));

    a_no_read_when_empty : assert property (@(posedge rclk) disable iff (!rst)
        !(fifo_r_en && fifo_empty));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: randomized and directed stimulus against a
// FIFO/stream reference model, with a scoreboard monitor sampling on the falling edge.
module tb_fifo_rd_stream;

    localparam int DATA = 14;
    localparam int CNTW = 4;

    logic            rclk = 1'b0;
    logic            rst = 1'b0;
    logic            en = 1'b0;
    logic            fifo_empty = 1'b1;
    logic [DATA-1:0] fifo_data = '0;
    logic            fifo_r_en;
    logic [DATA-1:0] m_data;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [CNTW-1:0] rd_count;
    logic            idle;

    fifo_rd_stream #(.DATA(DATA), .CNTW(CNTW)) dut (
        .rclk       (rclk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_r_en  (fifo_r_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .rd_count   (rd_count),
        .idle       (idle)
    );

    always #5 rclk = ~rclk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA-1:0] fifo_q[$];   // words stored in the modelled FIFO
    logic [DATA-1:0] exp_q[$];    // words expected downstream, in order

    logic rd_req    = 1'b0;       // fifo_r_en as seen just before the coming edge
    logic last_read = 1'b0;       // a read was taken at the previous edge
    int   reads     = 0;          // reads taken by the FIFO model
    int   pops      = 0;          // words accepted downstream
    int   delivered = 0;
    logic            prev_stall = 1'b0;
    logic [DATA-1:0] prev_data  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO model: registered read data, zero when no read; the empty flag follows the
    // store one edge late, like a real write-to-read crossing.
    always @(posedge rclk) begin
        if (rd_req && fifo_q.size() > 0) begin
            fifo_data <= fifo_q.pop_front();
        end else begin
            fifo_data <= '0;
        end
        fifo_empty <= (fifo_q.size() == 0);
        last_read  <= rd_req;
        if (rd_req) reads <= reads + 1;
    end

    // Monitor / scoreboard.
    always @(negedge rclk) begin
        int held;
        logic exp_valid;
        logic [DATA-1:0] w;
        held      = reads - pops;
        exp_valid = (held - int'(last_read)) > 0;
        if (rst) begin
            check("m_valid", m_valid, exp_valid);
            check("idle", idle, held == 0);
            check("fifo_r_en", fifo_r_en,
                  en && !fifo_empty && ((held - int'(exp_valid && m_ready)) < 2));
            check("occupancy bound", held <= 2, 1'b1);
            if (prev_stall) begin
                check("stall valid hold", m_valid, 1'b1);
                check("stall data hold", m_data, prev_data);
            end
            if (exp_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard: word delivered, none expected at %0t", $time);
                end else begin
                    w = exp_q.pop_front();
                    check("m_data", m_data, w);
                end
                check("rd_count", rd_count, (delivered % (1 << CNTW)));
                delivered <= delivered + 1;
                pops      <= pops + 1;
            end
            prev_stall <= m_valid && !m_ready;
            prev_data  <= m_data;
        end
        rd_req <= fifo_r_en;
    end

    task automatic push(input logic [DATA-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    task automatic wait_drain(input int limit);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || !idle) && c < limit) begin
            tick(1);
            c++;
        end
        check("drain queue empty", exp_q.size(), 0);
        check("drain idle", idle, 1'b1);
    endtask

    initial begin
        int base;
        int c;

        // Reset held with a word available and reads enabled.
        rst = 1'b0;
        en = 1'b1;
        m_ready = 1'b1;
        push(14'h0001);
        tick(3);
        @(negedge rclk);
        check("reset fifo_r_en", fifo_r_en, 1'b0);
        check("reset m_valid", m_valid, 1'b0);
        check("reset m_data", m_data, 14'h0000);
        check("reset rd_count", rd_count, 4'd0);
        check("reset idle", idle, 1'b1);
        check("reset fifo_empty seen", fifo_empty, 1'b0);
        @(posedge rclk);
        #1;
        rst = 1'b1;
        @(negedge rclk);
        check("first read after release", fifo_r_en, 1'b1);

        // Streaming 0x0001..0x0008.
        @(posedge rclk);
        #1;
        for (int i = 2; i <= 8; i++) push(DATA'(i));
        wait_drain(100);
        check("stream rd_count", rd_count, 4'd8);

        // Backpressure: only two reads may be outstanding.
        m_ready = 1'b0;
        base = reads;
        for (int i = 1; i <= 8; i++) push(DATA'(14'h0100 + i));
        tick(12);
        check("backpressure reads", reads - base, 2);
        check("backpressure head", m_data, 14'h0101);
        check("backpressure valid", m_valid, 1'b1);
        m_ready = 1'b1;
        wait_drain(100);

        // Empty boundary and resume latency.
        base = reads;
        for (int i = 1; i <= 3; i++) push(DATA'(14'h0200 + i));
        wait_drain(100);
        check("empty boundary reads", reads - base, 3);
        check("no read while empty", fifo_r_en, 1'b0);
        tick(5);
        push(14'h0204);
        c = 0;
        while (!fifo_r_en && c < 10) begin
            tick(1);
            c++;
        end
        check("resume read issued", fifo_r_en, 1'b1);
        tick(1);
        check("latency not early", m_valid, 1'b0);
        tick(1);
        check("latency 2 cycles", m_valid, 1'b1);
        check("resume data", m_data, 14'h0204);
        wait_drain(100);

        // en dropped right after a read issues.
        en = 1'b0;
        for (int i = 1; i <= 3; i++) push(DATA'(14'h0300 + i));
        tick(3);
        check("en low no read", fifo_r_en, 1'b0);
        base = reads;
        en = 1'b1;
        tick(1);
        en = 1'b0;
        tick(6);
        check("en toggle reads", reads - base, 1);
        check("en toggle remaining", exp_q.size(), 2);
        en = 1'b1;
        wait_drain(100);

        // Randomized traffic, backpressure and enable.
        for (int i = 0; i < 400; i++) begin
            tick(1);
            if ($urandom_range(3) == 0) push(DATA'($urandom));
            m_ready = ($urandom_range(2) != 0);
            en      = ($urandom_range(7) != 0);
        end
        en = 1'b1;
        m_ready = 1'b1;
        wait_drain(200);
        @(negedge rclk);
        check("final rd_count wrap", rd_count, (delivered % (1 << CNTW)));
        check("wrapped at least once", delivered >= 17, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer for the dual-clock FIFO; sits entirely in the rclk domain.
- Drives the FIFO read enable and captures the registered read data, which is valid only in the cycle after a read.
- Re-presents the captured words downstream on a valid/ready stream with a 2-entry skid buffer, so sustained throughput is 1 word/cycle with no loss under backpressure.
- Also provides a delivered-word counter and an idle indication for drain/shutdown sequencing.

Parameters:
- DATA, 14, data word width; matches the FIFO data width.
- CNTW, 16, width of the delivered-word counter.

Ports:
- rclk  input  1  read-domain clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  read enable from control; 0 stops new FIFO reads, and buffered words still drain.
- fifo_empty  input  1  FIFO empty flag (rclk domain).
- fifo_data  input  DATA  FIFO registered read data; valid only in the cycle after fifo_r_en=1 with fifo_empty=0.
- fifo_r_en  output  1  FIFO read request.
- m_data  output  DATA  downstream data (head of skid buffer).
- m_valid  output  1  downstream valid.
- m_ready  input  1  downstream ready.
- rd_count  output  CNTW  words accepted downstream (m_valid&m_ready), wraps modulo 2^CNTW.
- idle  output  1  1 when the buffer is empty and no read is in flight.

Behaviour:
- Reset (rst=0, asynchronous), all state cleared:
  - occ=0, inflight=0, m_valid=0, m_data=0, rd_count=0.
  - idle=1 and fifo_r_en=0 for as long as rst=0.
- State:
  - occ (0..2): number of words held in the skid buffer.
  - inflight (1 bit): a read was issued last cycle.
- pop = m_valid & m_ready.
- Issue rule (combinational): fifo_r_en = rst & en & ~fifo_empty & ((occ + inflight - pop) < 2).
  - The FIFO is never read without guaranteed space.
  - fifo_r_en must never be 1 while fifo_empty=1.
- inflight <= fifo_r_en each cycle.
- Capture: when inflight=1, fifo_data is written into the buffer in that same cycle.
  - Written to the head if the buffer is empty or the head is being popped with nothing behind it; otherwise written to the second slot.
  - fifo_data is never sampled when inflight=0; the FIFO drives 0 there.
- Buffer update per cycle, in order: pop the head if pop, shift slot1 to the head, then append the capture.
  - occ_next = occ - pop + inflight. It never exceeds 2; exceeding it is an assertion failure.
- m_valid = (occ != 0), registered.
  - m_data is stable while m_valid=1 and m_ready=0.
- Latency: a FIFO word read at cycle N appears on m_data/m_valid at cycle N+2 when the buffer is empty.
- Sustained rate: with m_ready=1 and the FIFO non-empty, one word per cycle after the 2-cycle fill.
- Backpressure: with m_ready=0, at most 2 words accumulate (occ + inflight ≤ 2), then fifo_r_en=0.
- en deassert mid-stream: no new reads from the next cycle. A read already in flight is still captured, and all buffered words drain normally.
- fifo_empty rising: reads stop with no data loss. The in-flight word, if any, is captured.
- rd_count increments by 1 on each pop and wraps from 2^CNTW-1 to 0.
- idle = (occ==0) & ~inflight.
- Reset asserted mid-transfer: buffered and in-flight words are discarded. The FIFO pointer has already advanced for an in-flight read; that loss is accepted at system level.

Test Plan:
- Reset: rst=0 with en=1 and fifo_empty=0 -> fifo_r_en=0, m_valid=0, rd_count=0, idle=1. After release, first fifo_r_en=1 on the next edge.
- Streaming: FIFO preloaded with 0x0001..0x0008, en=1, m_ready=1 -> m_data 0x0001..0x0008 on 8 consecutive cycles starting 2 cycles after the first read; rd_count=8; idle=1 after drain.
- Backpressure: 8 words queued, m_ready=0 -> exactly 2 reads issued, occ=2, m_data=0x0001 held stable. Then m_ready=1 -> all 8 delivered in order, no duplicates, no gaps.
- Empty boundary: 3 words queued, m_ready=1 -> 3 reads, fifo_r_en=0 once fifo_empty=1, m_valid falls after word 0x0003. Writing 0x0004 later resumes with the same 2-cycle latency.
- en toggle: en dropped the cycle after a read issues -> that word is still delivered and no further reads occur. en=1 again -> the stream resumes with the next word.
- Counter wrap (CNTW=4): 17 words delivered -> rd_count goes 15->0 and ends at 1.
